jtkiwi_romslot: RTL and testbench
=================================

# jtkiwi_romslot

Responder end of the CPU ROM request interface (`*_addr`/`*_cs` in, `*_ok`/`*_data` out). It serves byte reads for one CPU, such as the main or sub Z80, from a two-line, 32-bit-per-line cache. Misses are filled from the SDRAM controller through a req/ack/dok handshake. One instance sits between each CPU ROM port and its SDRAM bank slot.

## Interface
Parameters:
- `AW`, 15: CPU byte-address width.
- `SAW`, 22: SDRAM 16-bit-word address width.
- `OFFSET`, 22'h0: SDRAM word offset of this ROM region.

Ports:
- `clk` in 1: system clock; every register in the block uses it.
- `rstn` in 1: reset; synchronous and active-low.
- `clr` in 1: invalidate both lines; driven high during ROM download.
- `addr` in AW: CPU byte address.
- `cs` in 1: CPU read request.
- `ok` out 1: `dout` is valid for the current `addr`.
- `dout` out 8: read byte.
- `sdram_addr` out SAW: word address of the line fill.
- `sdram_req` out 1: fill request.
- `sdram_ack` in 1: controller accepted the request (one-cycle pulse).
- `sdram_dok` in 1: `sdram_data` valid (one-cycle pulse).
- `sdram_data` in 32: fill data; word at `sdram_addr` in [15:0], next word in [31:16].

## Operation
- Line tag is `addr[AW-1:2]`; byte select is `addr[1:0]`, little-endian (byte 0 = `data[7:0]`).
- Each line holds `valid`, `tag` and 32-bit `data`. One LRU bit points to the victim line.
- Hit = `valid & (tag == addr[AW-1:2])` on either line.
- `ok` = `cs & hit & ~clr`, combinational.
- `dout` is a combinational mux of the hit line's byte. When there is no hit it returns the last hit byte (registered); it never returns X.
- On a hit, the LRU bit is set to point at the other line on the next clock.
- States of the FSM (in the package):
  - IDLE: on `cs & ~hit & ~clr`, latch `tag_q = addr[AW-1:2]`, pick the victim from LRU, clear the victim's valid bit, and go to REQ.
  - REQ: `sdram_req = 1`, `sdram_addr = OFFSET + {tag_q, 1'b0}`. On `sdram_ack`, drop `req` in the same cycle and go to WAIT.
  - WAIT: on `sdram_dok`, write data and `tag_q` into the victim line, set `valid` unless the fill is discarded, point LRU at the other line, and go to IDLE.
- Hits on the non-victim line are served in every state.
- A fill always completes once requested, even if `cs` drops or `addr` changes. After IDLE returns, the new address is evaluated normally.
- `clr`:
  - Clears both valid bits in the cycle it is sampled.
  - If `clr` is seen in REQ or WAIT, the pending fill is marked discard: its data is written but `valid` stays 0.
  - While `clr` is high, no new request starts.
- `sdram_ack` and `sdram_dok` in the same cycle while in REQ: treat it as ack followed by dok, i.e. fill and go directly to IDLE.
- Address arithmetic: `{tag_q, 1'b0}` is zero-extended to SAW before the add. The sum wraps modulo 2^SAW.

## Timing
- Reset values: `ok = 0`, `dout = 0`, `sdram_req = 0`, `sdram_addr = OFFSET`, state IDLE, both valid bits 0, LRU = 0.
- Hit latency: 0 cycles (`ok` in the same cycle as `cs`/`addr`).
- Miss:
  - `sdram_req` rises 1 cycle after `cs`.
  - `ok` rises 1 cycle after `sdram_dok`.
  - Total = 2 + controller latency.
- `sdram_req` is held stable, with a stable `sdram_addr`, until `ack`. It is low in the cycle after `ack`.
- `rstn` low mid-transaction: `req` drops on the next edge. Any late `ack`/`dok` arriving in IDLE is ignored.

## Structure
- Package `jtkiwi_romslot_pkg`: state enum (IDLE, REQ, WAIT) and the line-width constant LW = 32.
- Sub-module `jtkiwi_romslot_line`: one line's valid/tag/data registers, tag compare, byte mux, and write port. It is instantiated twice.
- The top holds the FSM, LRU bit, discard flag, and output muxing.

## Test plan
- Cold miss: reset, then `cs=1`, `addr=15'h0005`.
  - Expect `req` with `sdram_addr=OFFSET+22'h2`.
  - After ack and `dok` with `data=32'hDDCCBBAA`, expect `ok=1`, `dout=8'hBB` one cycle later.
- Same-line hit: after the fill, `addr=15'h0007` gives `ok=1`, `dout=8'hDD` in the same cycle, with no `req`.
- Eviction:
  - Fill tag 1, then tag 2, then touch tag 1.
  - Then miss on tag 3: the line holding tag 2 must be replaced, and tag 1 must still hit.
- `clr` during WAIT:
  - Assert `clr` for 1 cycle between ack and `dok`.
  - After `dok`, `ok` stays 0 and a new `req` is issued for the same address.
- Address change mid-fill:
  - Move `addr` from 15'h0010 to 15'h0100 before `dok`.
  - Line 0x004 is filled, then a second `req` with `sdram_addr=OFFSET+22'h80` follows.
- Reset mid-REQ: `rstn=0` for 1 cycle while `req=1` drops `req` on the next edge; both lines miss afterwards.

Source files
------------

// File: rtl/jtkiwi_romslot_pkg.sv
// Shared types and constants for the CPU ROM slot cache.
package jtkiwi_romslot_pkg;

    localparam int unsigned LW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/jtkiwi_romslot_line.sv
// One cache line: valid/tag/data registers, tag compare, byte read and fill write port.
module jtkiwi_romslot_line
    import jtkiwi_romslot_pkg::*;
#(
    parameter int unsigned TW = 13
)(
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          clr_i,
    input  logic          inv_i,
    input  logic          we_i,
    input  logic          wr_valid_i,
    input  logic [TW-1:0] wr_tag_i,
    input  logic [LW-1:0] wr_data_i,
    input  logic [TW-1:0] rd_tag_i,
    input  logic [1:0]    rd_sel_i,
    output logic          hit_o,
    output logic [7:0]    rd_byte_o
);

    logic          valid_q, valid_d;
    logic [TW-1:0] tag_q, tag_d;
    logic [LW-1:0] data_q, data_d;

    // A fill write wins over invalidation; the caller folds clr into wr_valid_i.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (clr_i || inv_i) valid_d = 1'b0;
        if (we_i) begin
            valid_d = wr_valid_i;
            tag_d   = wr_tag_i;
            data_d  = wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit_o     = valid_q && (tag_q == rd_tag_i);
    assign rd_byte_o = data_q[{rd_sel_i, 3'b000} +: 8];

endmodule

// File: rtl/jtkiwi_romslot.sv
// CPU ROM byte-read responder with a two-line, 32-bit-per-line cache filled from SDRAM.
module jtkiwi_romslot
    import jtkiwi_romslot_pkg::*;
#(
    parameter int unsigned    AW     = 15,
    parameter int unsigned    SAW    = 22,
    parameter logic [SAW-1:0] OFFSET = '0
)(
    input  logic           clk,
    input  logic           rstn,
    input  logic           clr,
    input  logic [AW-1:0]  addr,
    input  logic           cs,
    output logic           ok,
    output logic [7:0]     dout,
    output logic [SAW-1:0] sdram_addr,
    output logic           sdram_req,
    input  logic           sdram_ack,
    input  logic           sdram_dok,
    input  logic [LW-1:0]  sdram_data
);

    localparam int unsigned TW = AW - 2;

    state_t        state_q, state_d;
    logic [TW-1:0] tag_q, tag_d;
    logic          lru_q, lru_d;
    logic          victim_q, victim_d;
    logic          discard_q, discard_d;
    logic [7:0]    last_q, last_d;

    logic          start, fill, hit;
    logic [1:0]    line_hit;
    logic [7:0]    line_byte [2];

    for (genvar i = 0; i < 2; i++) begin : g_line
        jtkiwi_romslot_line #(.TW(TW)) u_line (
            .clk_i      (clk),
            .rstn_i     (rstn),
            .clr_i      (clr),
            .inv_i      (start && (lru_q == 1'(i))),
            .we_i       (fill && (victim_q == 1'(i))),
            .wr_valid_i (!(discard_q || clr)),
            .wr_tag_i   (tag_q),
            .wr_data_i  (sdram_data),
            .rd_tag_i   (addr[AW-1:2]),
            .rd_sel_i   (addr[1:0]),
            .hit_o      (line_hit[i]),
            .rd_byte_o  (line_byte[i])
        );
    end

    assign hit = |line_hit;

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs && !hit && !clr) state_d = REQ;
            REQ:     if (sdram_ack) state_d = sdram_dok ? IDLE : WAIT;
            WAIT:    if (sdram_dok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ack and dok together in REQ complete the fill directly.
    always_comb begin
        sdram_req = 1'b0;
        start     = 1'b0;
        fill      = 1'b0;
        case (state_q)
            IDLE: start = cs && !hit && !clr;
            REQ: begin
                sdram_req = !sdram_ack;
                fill      = sdram_ack && sdram_dok;
            end
            WAIT:    fill = sdram_dok;
            default: ;
        endcase
    end

    always_comb begin
        tag_d     = start ? addr[AW-1:2] : tag_q;
        victim_d  = start ? lru_q : victim_q;
        discard_d = discard_q;
        if (start)                discard_d = 1'b0;
        else if (state_q != IDLE) discard_d = discard_q || clr;
        lru_d = lru_q;
        if (fill)           lru_d = !victim_q;
        else if (cs && hit) lru_d = line_hit[0];
        last_d = hit ? dout : last_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tag_q     <= '0;
            lru_q     <= 1'b0;
            victim_q  <= 1'b0;
            discard_q <= 1'b0;
            last_q    <= '0;
        end else begin
            tag_q     <= tag_d;
            lru_q     <= lru_d;
            victim_q  <= victim_d;
            discard_q <= discard_d;
            last_q    <= last_d;
        end
    end

    assign ok         = cs && hit && !clr;
    assign dout       = line_hit[0] ? line_byte[0] : (line_hit[1] ? line_byte[1] : last_q);
    assign sdram_addr = OFFSET + SAW'({tag_q, 1'b0});

endmodule

// File: tb/tb_jtkiwi_romslot.sv
// Directed bench for jtkiwi_romslot with a transaction-level cache model checked every cycle.
module tb_jtkiwi_romslot;

    localparam int          AW  = 15;
    localparam int          SAW = 22;
    localparam logic [21:0] OFF = 22'h3FF000;

    logic        clk = 1'b0, rstn = 1'b0, clr = 1'b0, cs = 1'b0;
    logic        sdram_ack = 1'b0, sdram_dok = 1'b0;
    logic [14:0] addr = '0;
    logic [31:0] sdram_data = '0;
    logic        ok, sdram_req;
    logic [7:0]  dout;
    logic [21:0] sdram_addr;

    int n_cmp = 0;
    int n_bad = 0;

    jtkiwi_romslot #(.AW(AW), .SAW(SAW), .OFFSET(OFF)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (clr),
        .addr       (addr),
        .cs         (cs),
        .ok         (ok),
        .dout       (dout),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .sdram_dok  (sdram_dok),
        .sdram_data (sdram_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] s);
        return 8'(w >> (8 * s));
    endfunction

    // Model: two cached lines, an LRU pointer, the last byte served and one outstanding fill.
    logic        mv [2];
    logic [12:0] mt [2];
    logic [31:0] md [2];
    logic        mlru, pend, acked, disc, fvict;
    logic [7:0]  mlast;
    logic [12:0] ftag;
    bit          known = 0;

    always @(negedge clk) begin
        logic        h0, h1, done, was_pend;
        logic [7:0]  de;
        logic [12:0] t;
        logic [21:0] ea;
        t  = addr[14:2];
        h0 = known && mv[0] && (mt[0] == t);
        h1 = known && mv[1] && (mt[1] == t);
        de = h0 ? byte_of(md[0], addr[1:0]) : (h1 ? byte_of(md[1], addr[1:0]) : mlast);
        ea = OFF + {8'b0, ftag, 1'b0};
        if (known) begin
            check("ok", ok, cs && (h0 || h1) && !clr);
            check("dout", dout, de);
            check("req", sdram_req, pend && !acked && !sdram_ack);
            check("sdram_addr", sdram_addr, ea);
        end
        if (!rstn) begin
            mv = '{1'b0, 1'b0}; mt = '{13'd0, 13'd0}; md = '{32'd0, 32'd0};
            mlru = 0; mlast = 0; pend = 0; acked = 0; disc = 0; fvict = 0; ftag = 0;
            known = 1;
        end else if (known) begin
            done     = 0;
            was_pend = pend;
            if (pend) begin
                if (clr) disc = 1;
                if (!acked) begin
                    if (sdram_ack) begin acked = 1; done = sdram_dok; end
                end else begin
                    done = sdram_dok;
                end
            end
            if (clr) begin mv[0] = 0; mv[1] = 0; end
            if (done) begin
                md[fvict] = sdram_data; mt[fvict] = ftag; mv[fvict] = !disc;
                mlru = !fvict; pend = 0;
            end else if (cs && (h0 || h1)) begin
                mlru = h0;
            end
            if (h0 || h1) mlast = de;
            if (!was_pend && cs && !(h0 || h1) && !clr) begin
                pend = 1; acked = 0; disc = 0; ftag = t; fvict = mlru; mv[mlru] = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!sdram_req && n < 20) begin tick(); n++; end
        check({nm, "_req_seen"}, sdram_req, 1);
    endtask

    // mode 0: plain fill, 1: clr between ack and dok, 2: addr moves to 0x100 before dok, 3: ack+dok together
    task automatic serve(input logic [31:0] d, input int mode);
        sdram_data = d;
        sdram_ack  = 1;
        if (mode == 3) sdram_dok = 1;
        tick();
        sdram_ack = 0;
        sdram_dok = 0;
        if (mode != 3) begin
            if (mode == 1) clr = 1;
            if (mode == 2) addr = 15'h0100;
            tick();
            clr = 0;
            sdram_dok = 1;
            tick();
            sdram_dok = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rstn = 0;
        tick(); tick();
        check("rst_ok", ok, 0);
        check("rst_dout", dout, 0);
        check("rst_req", sdram_req, 0);
        check("rst_addr", sdram_addr, OFF);
        rstn = 1;

        cs = 1; addr = 15'h0005;
        tick();
        check("cold_req", sdram_req, 1);
        check("cold_addr", sdram_addr, 22'h3FF002);
        tick();
        check("cold_req_hold", sdram_req, 1);
        serve(32'hDDCCBBAA, 0);
        check("cold_ok", ok, 1);
        check("cold_dout", dout, 8'hBB);
        addr = 15'h0007; #1;
        check("hit_ok", ok, 1);
        check("hit_dout", dout, 8'hDD);
        check("hit_noreq", sdram_req, 0);
        tick();

        addr = 15'h0008; tick(); wait_req("t2"); serve(32'h44332211, 0);
        check("t2_dout", dout, 8'h11);
        addr = 15'h0004; tick();
        addr = 15'h000C; tick(); wait_req("t3"); serve(32'h88776655, 0);
        check("t3_dout", dout, 8'h55);
        addr = 15'h0004; #1;
        check("evict_keep1_ok", ok, 1);
        check("evict_keep1_dout", dout, 8'hAA);
        addr = 15'h0008; #1;
        check("evict_t2_gone", ok, 0);
        cs = 0; tick();

        cs = 1; addr = 15'h0020; tick(); wait_req("clr"); serve(32'hCAFEF00D, 1);
        check("clr_ok", ok, 0);
        tick();
        check("clr_rereq", sdram_req, 1);
        check("clr_readdr", sdram_addr, 22'h3FF010);
        serve(32'hCAFEF00D, 0);
        check("clr_refill_ok", ok, 1);
        check("clr_refill_dout", dout, 8'h0D);

        addr = 15'h0010; tick(); wait_req("mv"); serve(32'h0BADF00D, 2);
        check("mv_ok_after", ok, 0);
        tick();
        check("mv_rereq", sdram_req, 1);
        check("mv_readdr", sdram_addr, 22'h3FF080);
        serve(32'h12345678, 0);
        check("mv_new_dout", dout, 8'h78);
        addr = 15'h0011; #1;
        check("mv_old_ok", ok, 1);
        check("mv_old_dout", dout, 8'hF0);
        tick();

        addr = 15'h2000; tick(); wait_req("wrap");
        check("wrap_addr", sdram_addr, 22'h000000);
        serve(32'h5A5A5AA5, 3);
        check("same_cycle_ok", ok, 1);
        check("same_cycle_dout", dout, 8'hA5);

        addr = 15'h0030; tick(); wait_req("rstmid");
        rstn = 0; tick();
        check("rst_mid_req", sdram_req, 0);
        rstn = 1; cs = 0;
        sdram_ack = 1; sdram_dok = 1; sdram_data = 32'hFFFFFFFF;
        tick();
        sdram_ack = 0; sdram_dok = 0;
        check("late_ack_req", sdram_req, 0);
        cs = 1; addr = 15'h2000; #1;
        check("rst_miss_a", ok, 0);
        addr = 15'h0100; #1;
        check("rst_miss_b", ok, 0);
        cs = 0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
